// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst master and its read skid buffer.
package ram_pkg;

  // Default RAM geometry: 8-bit words, 64 locations.
  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 6;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } burst_state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry valid/ready FIFO that absorbs RAM read data while the consumer
// stalls. Entry 0 is always the head; a pop shifts entry 1 down.
module ram_rd_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic [1:0]        count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] entry0_q, entry0_d;
  logic [DATA_W-1:0] entry1_q, entry1_d;
  logic [1:0]        count_q, count_d;
  logic              pop_s;

  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = entry0_q;
  assign count    = count_q;
  assign pop_s    = rd_valid & rd_ready;

  // Next entry contents and occupancy for every push/pop combination.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    case ({push, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          entry0_d = din;
          count_d  = 2'd1;
        end else if (count_q == 2'd1) begin
          entry1_d = din;
          count_d  = 2'd2;
        end else begin
          // Full: the issue throttle upstream never lets this happen.
          count_d = count_q;
        end
      end
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          entry0_d = entry1_q;
          entry1_d = din;
        end else begin
          entry0_d = din;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= {DATA_W{1'b0}};
      entry1_q <= {DATA_W{1'b0}};
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM. Accepts one command at a
// time and streams write beats into, or read beats out of, the RAM.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  burst_state_t      state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic              inflight_q, inflight_d;

  logic [1:0]        count_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic              issue_s;

  // ram_q is valid the cycle after an issue, so inflight doubles as the push.
  ram_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .din      (ram_q),
    .count    (count_s),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data)
  );

  assign pop_s = rd_valid & rd_ready;
  // Beats buffered plus beats still coming back from the RAM.
  assign occ_s = {1'b0, count_s} + {2'b00, inflight_q};
  // A pop frees a slot in the same cycle, so issue never bubbles at full rate.
  assign issue_s = (state_q == READ) && ((occ_s < 3'd2) || pop_s);

  // Next-state, counters and RAM/handshake outputs.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    inflight_d = 1'b0;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    wr_ready   = 1'b0;
    ram_we     = 1'b0;
    ram_data   = {DATA_W{1'b0}};
    ram_addr   = cur_addr_q;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          remain_d   = cmd_len;
          state_d    = cmd_write ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        ram_data = wr_data;
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (remain_q == {ADDR_W{1'b0}}) begin
            state_d = IDLE;
          end else begin
            remain_d = remain_q - ADDR_W'(1);
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        if (issue_s) begin
          inflight_d = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (remain_q == {ADDR_W{1'b0}}) begin
            state_d = DRAIN;
          end else begin
            remain_d = remain_q - ADDR_W'(1);
          end
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        // Leave as soon as the skid will be empty after this cycle's pop.
        if (!inflight_q && ((count_s == 2'd0) || ((count_s == 2'd1) && pop_s))) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address, beat counter and read-inflight registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= {ADDR_W{1'b0}};
      remain_q   <= {ADDR_W{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master with a behavioural RAM attached.
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [5:0] cmd_addr = 6'd0, cmd_len = 6'd0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = 8'd0;
  logic       rd_valid, rd_ready = 1'b1;
  logic [7:0] rd_data;
  logic       busy;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  logic [7:0] mem [64];
  logic [7:0] got [$];
  int         errors = 0;
  int         checks = 0;

  ram_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic cv, cw; logic [5:0] ca, cl; logic wv; logic [7:0] wd;
    logic e_cr, e_busy, e_wr, e_we; logic [5:0] e_addr; logic [7:0] e_data;
    logic e_rv; logic [7:0] e_rd;
  } vec_t;

  vec_t vt [29];

  function automatic vec_t mk(input logic cv, cw, input logic [5:0] ca, cl,
                              input logic wv, input logic [7:0] wd,
                              input logic cr, bz, wr, we, input logic [5:0] ad,
                              input logic [7:0] dt, input logic rv, input logic [7:0] rd);
    vec_t v;
    v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd;
    v.e_cr = cr; v.e_busy = bz; v.e_wr = wr; v.e_we = we; v.e_addr = ad;
    v.e_data = dt; v.e_rv = rv; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_data"}, ram_data, 0);
  endtask

  // Gap-free write burst of data base, base+1, ...
  task automatic wr_burst(input logic [5:0] a, input logic [5:0] l, input logic [7:0] base);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    for (int i = 0; i <= int'(l); i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = base + 8'(i);
      @(negedge clk);
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_addr, a + 6'(i));
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_idle", cmd_ready, 1);
  endtask

  // Read burst collecting popped beats; optional stall of stall_n cycles
  // once stall_at beats have been popped.
  task automatic rd_burst(input logic [5:0] a, input logic [5:0] l, input int stall_at,
                          input int stall_n, input logic [5:0] stall_addr);
    int  stall;
    bit  done;
    stall = 0;
    done  = 1'b0;
    got.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l; rd_ready = 1'b1;
    @(negedge clk);
    chk("rd_cmd_ready", cmd_ready, 1);
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (got.size() == stall_at && stall < stall_n) begin
        rd_ready = 1'b0;
        stall++;
      end else begin
        rd_ready = 1'b1;
      end
      @(negedge clk);
      if (!rd_ready) begin
        chk("stall_addr", ram_addr, stall_addr);
        chk("stall_rv", rd_valid, 1);
        chk("skid_le2", dut.u_skid.count_q <= 2'd2, 1);
      end
      if (rd_valid && rd_ready) got.push_back(rd_data);
      if (cmd_ready) done = 1'b1;
    end
    chk("rd_done", done, 1);
    rd_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Per-cycle vectors: write 01..03 @0, read back, wrap write/read @62,
    // then a command held through a busy write.
    vt[0]  = mk(1,1, 0,2, 0,8'h00, 1,0,0,0, 0,8'h00, 0,8'h00);
    vt[1]  = mk(0,0, 0,0, 1,8'h01, 0,1,1,1, 0,8'h01, 0,8'h00);
    vt[2]  = mk(0,0, 0,0, 1,8'h02, 0,1,1,1, 1,8'h02, 0,8'h00);
    vt[3]  = mk(0,0, 0,0, 1,8'h03, 0,1,1,1, 2,8'h03, 0,8'h00);
    vt[4]  = mk(1,0, 0,2, 0,8'h00, 1,0,0,0, 3,8'h00, 0,8'h00);
    vt[5]  = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 0,8'h00, 0,8'h00);
    vt[6]  = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 1,8'h00, 0,8'h00);
    vt[7]  = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 2,8'h00, 1,8'h01);
    vt[8]  = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 3,8'h00, 1,8'h02);
    vt[9]  = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 3,8'h00, 1,8'h03);
    vt[10] = mk(1,1,62,3, 0,8'h00, 1,0,0,0, 3,8'h00, 0,8'h00);
    vt[11] = mk(0,0, 0,0, 1,8'hAA, 0,1,1,1,62,8'hAA, 0,8'h00);
    vt[12] = mk(0,0, 0,0, 1,8'hBB, 0,1,1,1,63,8'hBB, 0,8'h00);
    vt[13] = mk(0,0, 0,0, 1,8'hCC, 0,1,1,1, 0,8'hCC, 0,8'h00);
    vt[14] = mk(0,0, 0,0, 1,8'hDD, 0,1,1,1, 1,8'hDD, 0,8'h00);
    vt[15] = mk(1,0,62,3, 0,8'h00, 1,0,0,0, 2,8'h00, 0,8'h00);
    vt[16] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0,62,8'h00, 0,8'h00);
    vt[17] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0,63,8'h00, 0,8'h00);
    vt[18] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 0,8'h00, 1,8'hAA);
    vt[19] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 1,8'h00, 1,8'hBB);
    vt[20] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 2,8'h00, 1,8'hCC);
    vt[21] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0, 2,8'h00, 1,8'hDD);
    vt[22] = mk(1,1,10,0, 0,8'h00, 1,0,0,0, 2,8'h00, 0,8'h00);
    vt[23] = mk(1,0,10,0, 1,8'h55, 0,1,1,1,10,8'h55, 0,8'h00);
    vt[24] = mk(1,0,10,0, 0,8'h00, 1,0,0,0,11,8'h00, 0,8'h00);
    vt[25] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0,10,8'h00, 0,8'h00);
    vt[26] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0,11,8'h00, 0,8'h00);
    vt[27] = mk(0,0, 0,0, 0,8'h00, 0,1,0,0,11,8'h00, 1,8'h55);
    vt[28] = mk(0,0, 0,0, 0,8'h00, 1,0,0,0,11,8'h00, 0,8'h00);

    // Reset state.
    #12;
    chk_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
      cmd_valid = vt[i].cv; cmd_write = vt[i].cw; cmd_addr = vt[i].ca;
      cmd_len = vt[i].cl; wr_valid = vt[i].wv; wr_data = vt[i].wd; rd_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, vt[i].e_cr);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d_wr_ready", i), wr_ready, vt[i].e_wr);
      chk($sformatf("v%0d_ram_we", i), ram_we, vt[i].e_we);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, vt[i].e_addr);
      chk($sformatf("v%0d_ram_data", i), ram_data, vt[i].e_data);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vt[i].e_rv);
      if (vt[i].e_rv) chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].e_rd);
    end

    // Write gaps: wr_valid 1,0,1 over a 2-beat burst at address 20.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd20; cmd_len = 6'd1;
    @(negedge clk); chk("gap_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1; cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'h11;
    @(negedge clk); chk("gap_we0", ram_we, 1); chk("gap_addr0", ram_addr, 6'd20);
    @(posedge clk); #1; wr_valid = 1'b0; wr_data = 8'h99;
    @(negedge clk); chk("gap_we_idle", ram_we, 0); chk("gap_addr_idle", ram_addr, 6'd21);
    chk("gap_busy", busy, 1); chk("gap_wr_ready", wr_ready, 1);
    @(posedge clk); #1; wr_valid = 1'b1; wr_data = 8'h22;
    @(negedge clk); chk("gap_we1", ram_we, 1); chk("gap_addr1", ram_addr, 6'd21);
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk); chk("gap_done", cmd_ready, 1); chk("gap_final_addr", ram_addr, 6'd22);

    // Read backpressure: 8 beats at 30, stall 4 cycles after 2 pops.
    wr_burst(6'd30, 6'd7, 8'h80);
    rd_burst(6'd30, 6'd7, 2, 4, 6'd34);
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) chk($sformatf("bp_beat%0d", i), got[i], 8'h80 + 8'(i));

    // Gap burst read back: 11 @20, 22 @21.
    rd_burst(6'd20, 6'd1, -1, 0, 6'd0);
    chk("gap_rd_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("gap_rd0", got[0], 8'h11);
      chk("gap_rd1", got[1], 8'h22);
    end

    // Reset during beat 3 of a 6-beat read.
    got.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd30; cmd_len = 6'd5; rd_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 2; c++) begin
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(negedge clk);
      if (rd_valid && rd_ready) got.push_back(rd_data);
    end
    @(posedge clk); #1;
    chk("rst_pre_rv", rd_valid, 1);
    chk("rst_pre_data", rd_data, 8'h82);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    wr_burst(6'd40, 6'd1, 8'h5A);
    rd_burst(6'd40, 6'd1, -1, 0, 6'd0);
    chk("post_rst_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("post_rst0", got[0], 8'h5A);
      chk("post_rst1", got[1], 8'h5B);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
